// File: rtl/vram_line_fetcher.sv
// Small generic FIFO: power-of-two depth, push/pop in the same cycle, synchronous flush.
// Latency: a pushed word is visible on rd_dat/rd_vld the cycle after the push.
// Backpressure: the caller must not push when full; rd_vld drops only once the FIFO is empty.
// Ports: clock/reset, flush, wr_vld/wr_dat (push), rd_rdy (pop), rd_vld/rd_dat (head), count.
module vlf_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_rdy,
    output logic          rd_vld,
    output logic [W-1:0]  rd_dat,
    output logic [AW:0]   count
);
    logic [W-1:0]  store [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign rd_vld = (count != '0);
    // Head is forced to zero when empty so the stream outputs read zero at rest.
    assign rd_dat = rd_vld ? store[rd_ptr] : '0;
    assign wr_en  = wr_vld && !flush;
    assign rd_en  = rd_vld && rd_rdy && !flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) store[wr_ptr] <= wr_dat;
    end
endmodule

// Burst reader: streams `length` consecutive RAM words starting at base_addr out as valid/ready.
// Latency: first out_valid two edges after the start edge; one word per cycle while out_ready is high.
// Backpressure: reads are issued only while buffered + in-flight words fit in the FIFO, so it never overflows.
// Ports: clock/reset; start/base_addr/length/abort control; mem_addr/mem_rd/mem_q RAM port B;
//        out_data/out_valid/out_ready/out_last stream; busy/done status.
module vram_line_fetcher #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   left_q, left_d;
    logic              infl_q;
    logic              infl_last_q;
    logic              done_q;
    logic              done_set;
    logic              burst_end;
    logic              flush;
    logic              last_issue;
    logic [CW-1:0]     fifo_cnt;
    logic [CW:0]       occupancy;
    logic              fifo_wr_vld;

    // Words already buffered plus the one possibly returning from RAM this cycle.
    assign occupancy  = {1'b0, fifo_cnt} + {{CW{1'b0}}, infl_q};
    assign last_issue = (left_q == (ADDR_W+1)'(1));
    assign flush      = abort && (state_q != IDLE);
    // The return of a read issued just before an abort is dropped here.
    assign fifo_wr_vld = infl_q && !flush;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        left_d    = left_q;
        done_set  = 1'b0;
        burst_end = 1'b0;
        mem_rd    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d = FETCH;
                        addr_d  = base_addr;
                        left_d  = length;
                    end else begin
                        done_set = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (abort) begin
                    state_d  = IDLE;
                    done_set = 1'b1;
                end else if ((left_q != '0) && (occupancy < DEPTH_V)) begin
                    mem_rd = 1'b1;
                    addr_d = addr_q + 1'b1;
                    left_d = left_q - 1'b1;
                    if (last_issue) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d  = IDLE;
                    done_set = 1'b1;
                end else if (out_valid && out_ready && out_last) begin
                    state_d   = IDLE;
                    burst_end = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            left_q      <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            left_q      <= left_d;
            infl_q      <= mem_rd;
            infl_last_q <= mem_rd && last_issue;
            done_q      <= done_set;
        end
    end

    // The last flag travels with its data word through the FIFO.
    vlf_fifo #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .flush  (flush),
        .wr_vld (fifo_wr_vld),
        .wr_dat ({infl_last_q, mem_q}),
        .rd_rdy (out_ready),
        .rd_vld (out_valid),
        .rd_dat ({out_last, out_data}),
        .count  (fifo_cnt)
    );

    assign mem_addr = addr_q;
    assign busy     = (state_q != IDLE);
    // Normal completion pulses in the final transfer cycle; abort/zero-length pulse a cycle later.
    assign done     = done_q || burst_end;
endmodule

// File: tb/tb_vram_line_fetcher.sv
module tb_vram_line_fetcher;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic        abort;
    logic [9:0]  mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_q;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ram [1024];
    logic [9:0] q_rd [$];
    logic [8:0] q_out [$];
    logic       busy_seen;

    vram_line_fetcher #(.DATA_W(8), .ADDR_W(10), .DEPTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .abort     (abort),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_q     (mem_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    // RAM port B: one-cycle read latency.
    always @(posedge clock) if (mem_rd) mem_q <= ram[mem_addr];

    always @(negedge clock) begin
        if (mem_rd) q_rd.push_back(mem_addr);
        if (out_valid && out_ready) q_out.push_back({out_last, out_data});
        if (busy) busy_seen = 1'b1;
    end

    function automatic logic [7:0] fill(input int a);
        return 8'(a * 7 + 3);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic launch(input logic [9:0] b, input logic [10:0] n);
        base_addr = b;
        length    = n;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clock);
            if (done) break;
        end
        if (k == budget) check({tag, "_timeout"}, 32'd0, 32'd1);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_rd, exp_vld, exp_done, exp_busy;
        logic [9:0] exp_addr [4];
        int         vcnt;

        for (int i = 0; i < 1024; i++) ram[i] = fill(i);
        ram[16] = 8'hA0; ram[17] = 8'hA1; ram[18] = 8'hA2; ram[19] = 8'hA3;

        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; abort = 1'b0; out_ready = 1'b1;
        #1;
        check("rst_mem_rd", 32'(mem_rd), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_busy_done", {30'd0, busy, done}, 0);
        check("rst_out_data", 32'(out_data), 0);
        step();
        step();
        reset = 1'b0;
        step();

        // Basic burst, cycle-exact: c0 is the start cycle.
        exp_rd   = 8'b0001_1110;
        exp_vld  = 8'b0111_1000;
        exp_done = 8'b0100_0000;
        exp_busy = 8'b0111_1110;
        base_addr = 10'h010; length = 11'd4; start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            check($sformatf("b1_rd_c%0d", k), 32'(mem_rd), 32'(exp_rd[k]));
            check($sformatf("b1_vld_c%0d", k), 32'(out_valid), 32'(exp_vld[k]));
            check($sformatf("b1_done_c%0d", k), 32'(done), 32'(exp_done[k]));
            check($sformatf("b1_busy_c%0d", k), 32'(busy), 32'(exp_busy[k]));
            if (exp_rd[k]) check($sformatf("b1_addr_c%0d", k), 32'(mem_addr), 32'h10 + 32'(k - 1));
            if (exp_vld[k]) begin
                check($sformatf("b1_dat_c%0d", k), 32'(out_data), 32'hA0 + 32'(k - 3));
                check($sformatf("b1_last_c%0d", k), 32'(out_last), (k == 6) ? 32'd1 : 32'd0);
            end
            step();
            start = 1'b0;
        end

        // Address wrap; a start while busy must be ignored.
        q_rd.delete(); q_out.delete();
        launch(10'h3FE, 11'd4);
        base_addr = 10'h000; length = 11'd5; start = 1'b1;
        step();
        start = 1'b0;
        wait_done("wrap", 40);
        exp_addr[0] = 10'h3FE; exp_addr[1] = 10'h3FF; exp_addr[2] = 10'h000; exp_addr[3] = 10'h001;
        check("wrap_nreads", q_rd.size(), 4);
        check("wrap_nout", q_out.size(), 4);
        for (int i = 0; i < 4 && i < q_rd.size() && i < q_out.size(); i++) begin
            check($sformatf("wrap_addr%0d", i), 32'(q_rd[i]), 32'(exp_addr[i]));
            check($sformatf("wrap_out%0d", i), 32'(q_out[i]), {23'd0, (i == 3), fill(int'(exp_addr[i]))});
        end
        step();
        check("wrap_idle", 32'(busy), 0);

        // Stall: only DEPTH reads may be outstanding while out_ready is low.
        q_rd.delete(); q_out.delete();
        out_ready = 1'b0;
        launch(10'h100, 11'd8);
        repeat (10) step();
        check("stall_nreads", q_rd.size(), 4);
        check("stall_vld", 32'(out_valid), 1);
        check("stall_head", 32'(out_data), 32'(fill(10'h100)));
        step();
        check("stall_head_hold", 32'(out_data), 32'(fill(10'h100)));
        out_ready = 1'b1;
        wait_done("stall", 40);
        check("stall_nout", q_out.size(), 8);
        for (int i = 0; i < 8 && i < q_out.size(); i++)
            check($sformatf("stall_out%0d", i), 32'(q_out[i]), {23'd0, (i == 7), fill(32'h100 + i)});
        step();

        // Abort after the fifth transfer.
        q_rd.delete(); q_out.delete();
        launch(10'h200, 11'd16);
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            #1;
            if (q_out.size() >= 5) break;
        end
        check("abort_reach5", 32'(q_out.size() >= 5), 1);
        step();
        abort = 1'b1;
        @(negedge clock);
        check("abort_rd_low", 32'(mem_rd), 0);
        check("abort_busy_still", 32'(busy), 1);
        step();
        abort = 1'b0;
        @(negedge clock);
        check("abort_vld_off", 32'(out_valid), 0);
        check("abort_done", 32'(done), 1);
        check("abort_busy_off", 32'(busy), 0);
        step();
        @(negedge clock);
        check("abort_done_pulse", 32'(done), 0);
        check("abort_no_return", 32'(out_valid), 0);
        step();

        // Zero length, then abort while idle.
        q_rd.delete();
        busy_seen = 1'b0;
        launch(10'h050, 11'd0);
        @(negedge clock);
        check("zero_done", 32'(done), 1);
        step();
        @(negedge clock);
        check("zero_done_pulse", 32'(done), 0);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clock);
        check("idle_abort_done", 32'(done), 0);
        check("zero_nreads", q_rd.size(), 0);
        check("zero_busy_seen", 32'(busy_seen), 0);
        step();

        // Reset during DRAIN with three words buffered.
        out_ready = 1'b0;
        launch(10'h300, 11'd3);
        repeat (4) step();
        check("rdrain_busy", 32'(busy), 1);
        check("rdrain_vld", 32'(out_valid), 1);
        reset = 1'b1;
        #1;
        check("rdrain_outs", {mem_addr, out_data, 9'd0, mem_rd, out_valid, out_last, busy, done}, 0);
        step();
        out_ready = 1'b1;
        reset = 1'b0;
        vcnt = 0;
        busy_seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (out_valid) vcnt++;
        end
        check("rdrain_no_vld", vcnt, 0);
        check("rdrain_no_busy", 32'(busy_seen), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
